// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry and the register-address type.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW       = $clog2(NREG_DEF);

  typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending (awaiting writeback) bits with flush and a registered population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NWR-1:0]                    wr_en,
  input  logic [NWR-1:0][$clog2(NREG)-1:0]  wr_addr,
  input  logic                              issue_en,
  input  logic [$clog2(NREG)-1:0]           issue_addr,
  input  logic                              flush,
  output logic [NREG-1:0]                   pending,
  output logic [$clog2(NREG):0]             busy_cnt
);
  localparam int ADDR_W = $clog2(NREG);

  logic [NREG-1:0]   pend_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  // Writeback clears first so a same-cycle issue (new producer) wins; flush overrides both.
  always_comb begin
    pend_nxt = pending;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k]) pend_nxt[wr_addr[k]] = 1'b0;
    if (issue_en) pend_nxt[issue_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
    if (flush) pend_nxt = '0;
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[r]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      busy_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with x0 hardwired, same-cycle write bypass and a pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NRD-1:0][$clog2(NREG)-1:0]  rd_addr,
  output logic [NRD-1:0][XLEN-1:0]          rd_data,
  output logic [NRD-1:0]                    rd_busy,
  input  logic [NWR-1:0]                    wr_en,
  input  logic [NWR-1:0][$clog2(NREG)-1:0]  wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]          wr_data,
  input  logic                              issue_en,
  input  logic [$clog2(NREG)-1:0]           issue_addr,
  input  logic                              flush,
  output logic [$clog2(NREG):0]             busy_cnt
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           pending;

  // Ascending port order: the last non-blocking assignment (highest port) wins on conflicts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k] != '0) regs[wr_addr[k]] <= wr_data[k];
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic            hit;
    logic [XLEN-1:0] data;

    always_comb begin
      hit  = 1'b0;
      data = regs[rd_addr[i]];
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k] == rd_addr[i] && rd_addr[i] != '0) begin
          hit  = 1'b1;
          data = wr_data[k];
        end
    end

    assign rd_data[i] = data;
    assign rd_busy[i] = pending[rd_addr[i]] & ~hit;
  end

  regfile_scoreboard #(.NREG(NREG), .NWR(NWR)) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .pending    (pending),
    .busy_cnt   (busy_cnt)
  );
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of architectural registers (power of two, >=2).
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter NWR, default 2: number of write ports.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port rd_addr  in  NRD x AW  read addresses, where AW = clog2(NREG).
REQ-008 SHALL have port rd_data  out  NRD x XLEN  read data.
REQ-009 SHALL have port rd_busy  out  NRD  pending-write flag per read port.
REQ-010 SHALL have port wr_en  in  NWR  write enables.
REQ-011 SHALL have port wr_addr  in  NWR x AW  write addresses.
REQ-012 SHALL have port wr_data  in  NWR x XLEN  write data.
REQ-013 SHALL have port issue_en  in  1  marks issue_addr as awaiting writeback.
REQ-014 SHALL have port issue_addr  in  AW  destination register being issued.
REQ-015 SHALL have port flush  in  1  clears all pending flags.
REQ-016 SHALL have port busy_cnt  out  AW+1  number of registers currently pending.

Function
REQ-017 SHALL hardwire register 0: reads return 0, writes are ignored, and it is never marked pending.
REQ-018 SHALL commit a write to a nonzero wr_addr[k] on the rising edge when wr_en[k]=1.
REQ-019 SHALL, when several enabled write ports target the same address in one cycle, commit only the highest-index port.
REQ-020 SHALL drive rd_data combinationally from rd_addr.
REQ-021 SHALL bypass: when an enabled write targets a nonzero rd_addr[i] in the same cycle, rd_data[i] is that write's wr_data, following the REQ-019 priority.
REQ-022 SHALL keep one pending bit per register, set on the rising edge when issue_en=1 and issue_addr!=0.
REQ-023 SHALL clear a register's pending bit on the rising edge when any wr_en[k] targets that register.
REQ-024 SHALL, when an issue and a write target the same register in one cycle, leave its pending bit set (new producer wins).
REQ-025 SHALL treat a write to a non-pending register as a plain data update, with no change to any pending bit or busy_cnt.
REQ-026 SHALL, on flush=1, clear all pending bits at the next edge, overriding issue_en; writes in that cycle still commit data.
REQ-027 SHALL drive rd_busy[i] = pending[rd_addr[i]] AND NOT (any same-cycle write hits rd_addr[i]); rd_busy[i] SHALL be 0 for address 0.
REQ-028 SHALL make busy_cnt a registered population count of the pending bits, equal to the pending count after each edge.
REQ-029 SHALL never let busy_cnt underflow or exceed NREG-1.
REQ-030 SHALL add no latency on reads; write-to-read latency is 0 cycles via bypass and 1 cycle via the array.

Reset
REQ-031 SHALL, while reset_n=0, clear all registers to 0, all pending bits to 0 and busy_cnt to 0, asynchronously.
REQ-032 SHALL make rd_data and rd_busy reflect the cleared state during reset; bypass from wr_* remains combinational.
REQ-033 SHALL, when reset is asserted mid-operation, abandon all in-flight issues; no write is committed on the release edge unless wr_en=1 after release.

Structure
REQ-034 SHALL place XLEN and NREG defaults, the AW localparam and the register-address typedef in shared package regfile_pkg.
REQ-035 SHALL implement the pending bits, flush and busy_cnt in sub-module regfile_scoreboard; the data array and bypass muxes stay in the top level.

Verification
REQ-036 SHALL verify write-then-read: write x5=0xDEADBEEF on port 0, read x5 the same cycle -> rd_data=0xDEADBEEF, rd_busy=0; next cycle still 0xDEADBEEF.
REQ-037 SHALL verify register 0: write x0=0x1234 with issue_addr=0 -> rd_data for x0 = 0, busy_cnt = 0.
REQ-038 SHALL verify write-port conflict: port 0 writes x7=0x11 and port 1 writes x7=0x22 in one cycle -> bypass and later read both give 0x22.
REQ-039 SHALL verify the scoreboard: issue x3 then x4 -> busy_cnt=2; next, write x3 together with a new issue of x3 -> x3 stays pending, busy_cnt=2; then write x4 -> busy_cnt=1.
REQ-040 SHALL verify flush: with x1, x2 and x9 pending, assert flush together with issue x10 -> busy_cnt=0, rd_busy=0 for all four registers.
REQ-041 SHALL verify reset: load x1..x31 with nonzero values, assert reset_n=0 mid-cycle -> all reads 0 and busy_cnt 0 immediately, with no clock edge required.
